// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported memory between the fetch stage and the
//            memory stage of a pipelined core. One access is in flight at a
//            time; simultaneous requests alternate between the two ports.
//            A wait-cycle watchdog aborts accesses the memory never answers,
//            so the pipeline always receives a completion pulse.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            InstrReqF/PCF/FlushF - fetch request, address, branch redirect
//            DataReqM/DataWeM/ALUResultM/WriteDataM - load/store request
//            mem_ack/mem_rdata   - memory completion and read data
//            mem_req/mem_we/mem_addr/mem_wdata - registered memory request
//            InstrF/InstrValidF  - fetched instruction and completion pulse
//            ReadDataM/DataDoneM - load data and completion pulse
//            StallF/StallM       - combinational stalls to the hazard unit
//            MemErr              - sticky watchdog error flag
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        InstrReqF,
    input  logic [31:0] PCF,
    input  logic        FlushF,
    input  logic        DataReqM,
    input  logic        DataWeM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] InstrF,
    output logic        InstrValidF,
    output logic [31:0] ReadDataM,
    output logic        DataDoneM,
    output logic        StallF,
    output logic        StallM,
    output logic        MemErr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_WAIT = 2'd1,
        I_WAIT = 2'd2
    } state_t;

    localparam logic       GRANT_INSTR = 1'b0;
    localparam logic       GRANT_DATA  = 1'b1;
    // The abort fires in the wait cycle where the counter would reach TIMEOUT.
    localparam logic [7:0] C_WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q,       state_d;
    logic        mem_req_q,     mem_req_d;
    logic        mem_we_q,      mem_we_d;
    logic [31:0] mem_addr_q,    mem_addr_d;
    logic [31:0] mem_wdata_q,   mem_wdata_d;
    logic [31:0] instr_q,       instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] rdata_q,       rdata_d;
    logic        data_done_q,   data_done_d;
    logic        mem_err_q,     mem_err_d;
    logic [7:0]  wait_cnt_q,    wait_cnt_d;
    logic        stale_q,       stale_d;
    logic        last_grant_q,  last_grant_d;

    logic w_grant_ok;
    logic w_instr_elig;
    logic w_pick_data;
    logic w_stale_now;
    logic w_timeout;

    always_comb begin
        // A request that is completing this cycle is still asserted; holding
        // off the grant until the done pulse has passed avoids serving it twice.
        w_grant_ok   = ~data_done_q & ~instr_valid_q;
        w_instr_elig = InstrReqF & ~FlushF;
        w_pick_data  = DataReqM & (~w_instr_elig | (last_grant_q == GRANT_INSTR));
        w_stale_now  = stale_q | FlushF;
        w_timeout    = (wait_cnt_q == C_WAIT_LAST);

        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        rdata_d       = rdata_q;
        data_done_d   = 1'b0;
        mem_err_d     = mem_err_q;
        wait_cnt_d    = wait_cnt_q;
        stale_d       = stale_q;
        last_grant_d  = last_grant_q;

        case (state_q)
            IDLE: begin
                stale_d = 1'b0;
                // mem_ack is deliberately not looked at here.
                if (w_grant_ok) begin
                    if (w_pick_data) begin
                        state_d      = D_WAIT;
                        mem_req_d    = 1'b1;
                        mem_we_d     = DataWeM;
                        mem_addr_d   = ALUResultM;
                        mem_wdata_d  = WriteDataM;
                        wait_cnt_d   = 8'd0;
                        last_grant_d = GRANT_DATA;
                    end else if (w_instr_elig) begin
                        state_d      = I_WAIT;
                        mem_req_d    = 1'b1;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = PCF;
                        wait_cnt_d   = 8'd0;
                        last_grant_d = GRANT_INSTR;
                    end
                end
            end

            D_WAIT: begin
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    data_done_d = 1'b1;
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (w_timeout) begin
                        rdata_d     = 32'd0;
                        data_done_d = 1'b1;
                        mem_err_d   = 1'b1;
                        state_d     = IDLE;
                        mem_req_d   = 1'b0;
                    end
                end
            end

            I_WAIT: begin
                // A redirect seen at any point of the access, including the
                // ack cycle itself, makes the returned word useless.
                stale_d = w_stale_now;
                if (mem_ack) begin
                    if (!w_stale_now) begin
                        instr_d       = mem_rdata;
                        instr_valid_d = 1'b1;
                    end
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    stale_d   = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (w_timeout) begin
                        // A redirected fetch needs no completion: the fetch
                        // stage has already moved on and will re-request.
                        if (!w_stale_now) begin
                            instr_d       = 32'd0;
                            instr_valid_d = 1'b1;
                        end
                        mem_err_d = 1'b1;
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                        stale_d   = 1'b0;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'd0;
            mem_wdata_q   <= 32'd0;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            rdata_q       <= 32'd0;
            data_done_q   <= 1'b0;
            mem_err_q     <= 1'b0;
            wait_cnt_q    <= 8'd0;
            stale_q       <= 1'b0;
            last_grant_q  <= GRANT_INSTR;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            rdata_q       <= rdata_d;
            data_done_q   <= data_done_d;
            mem_err_q     <= mem_err_d;
            wait_cnt_q    <= wait_cnt_d;
            stale_q       <= stale_d;
            last_grant_q  <= last_grant_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign InstrF      = instr_q;
    assign InstrValidF = instr_valid_q;
    assign ReadDataM   = rdata_q;
    assign DataDoneM   = data_done_q;
    assign MemErr      = mem_err_q;
    assign StallF      = InstrReqF & ~instr_valid_q;
    assign StallM      = DataReqM & ~data_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. A transaction-level
//            model of the arbitration rules predicts which port is granted
//            and what each completion returns; predictions are queued and a
//            monitor compares them against every completion pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        InstrReqF, FlushF, DataReqM, DataWeM, mem_ack;
    logic [31:0] PCF, ALUResultM, WriteDataM, mem_rdata;
    logic        mem_req, mem_we, InstrValidF, DataDoneM, StallF, StallM, MemErr;
    logic [31:0] mem_addr, mem_wdata, InstrF, ReadDataM;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .InstrReqF(InstrReqF), .PCF(PCF), .FlushF(FlushF),
        .DataReqM(DataReqM), .DataWeM(DataWeM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .InstrF(InstrF), .InstrValidF(InstrValidF),
        .ReadDataM(ReadDataM), .DataDoneM(DataDoneM), .StallF(StallF),
        .StallM(StallM), .MemErr(MemErr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] v;
        logic        err;
    } exp_t;

    exp_t dq[$];
    exp_t iq[$];

    // Requester state as the pipeline sees it.
    bit          d_pend, i_pend;
    logic        d_we;
    logic [31:0] d_addr, d_wdata, i_pc;

    // Reference model: who was granted last, load data register, error flag.
    bit          last_data_m;
    logic [31:0] rd_m;
    bit          err_m;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    endtask

    task automatic req_data(input logic we, input logic [31:0] a, input logic [31:0] wd);
        DataReqM = 1'b1; DataWeM = we; ALUResultM = a; WriteDataM = wd;
        d_pend = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    endtask

    task automatic req_instr(input logic [31:0] pc);
        InstrReqF = 1'b1; PCF = pc;
        i_pend = 1'b1; i_pc = pc;
    endtask

    task automatic check_zero_outputs(input string tag);
        check(mem_req === 1'b0 && mem_we === 1'b0, {tag, "_req_we"}, {30'd0, mem_req, mem_we}, 32'd0);
        check(mem_addr === 32'd0, {tag, "_addr"}, mem_addr, 32'd0);
        check(mem_wdata === 32'd0, {tag, "_wdata"}, mem_wdata, 32'd0);
        check(InstrF === 32'd0, {tag, "_InstrF"}, InstrF, 32'd0);
        check(ReadDataM === 32'd0, {tag, "_ReadDataM"}, ReadDataM, 32'd0);
        check({InstrValidF, DataDoneM, MemErr} === 3'b000, {tag, "_pulses_err"},
              {29'd0, InstrValidF, DataDoneM, MemErr}, 32'd0);
    endtask

    // Serves one grant: n = cycles from grant to ack (n > TO means no ack),
    // flush_k = wait cycle in which FlushF is pulsed (0 = none), npc = the
    // redirect target presented with the flush.
    task automatic serve(input int n, input int flush_k,
                         input logic [31:0] rdata, input logic [31:0] npc);
        bit          is_data, to, stale, hold_ok, stall_ok;
        logic [31:0] ea;
        logic        ewe;
        int          k, limit;
        exp_t        e;
        is_data = d_pend && (!i_pend || !last_data_m);
        ea      = is_data ? d_addr : i_pc;
        ewe     = is_data ? d_we : 1'b0;
        to      = (n > TO);
        limit   = to ? TO : n;
        stale   = !is_data && !to && flush_k >= 1 && flush_k <= n;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (mem_req !== 1'b1 && k < 6);
        check(mem_req === 1'b1, "grant_seen", {31'd0, mem_req}, 32'd1);
        if (mem_req !== 1'b1) return;
        check(mem_addr === ea && mem_we === ewe && (!is_data || !ewe || mem_wdata === d_wdata),
              is_data ? "grant_data" : "grant_instr", mem_addr, ea);
        last_data_m = is_data;
        err_m = err_m | to;
        if (is_data) begin
            if (to) rd_m = 32'd0;
            else if (!ewe) rd_m = rdata;
            e.v = rd_m; e.err = err_m;
            dq.push_back(e);
        end else if (!stale) begin
            e.v = to ? 32'd0 : rdata; e.err = err_m;
            iq.push_back(e);
        end
        hold_ok  = 1'b1;
        stall_ok = 1'b1;
        for (int c = 1; c <= limit; c++) begin
            if (c > 1) @(negedge clk);
            hold_ok &= (mem_req === 1'b1 && mem_addr === ea && mem_we === ewe &&
                        (!is_data || mem_wdata === d_wdata));
            stall_ok &= (StallM === d_pend) && (StallF === i_pend);
            mem_ack   = (!to && c == n);
            mem_rdata = (!to && c == n) ? rdata : $urandom;
            FlushF    = (!to && c == flush_k);
            if (FlushF && !is_data) begin
                PCF = npc; i_pc = npc;
            end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        FlushF  = 1'b0;
        check(mem_req === 1'b0, "req_released", {31'd0, mem_req}, 32'd0);
        check(hold_ok, "req_held_stable", mem_addr, ea);
        check(stall_ok, "stall_during_wait", {30'd0, StallF, StallM}, {30'd0, i_pend, d_pend});
        #1;
        if (is_data)
            check(StallM === 1'b0, "stallM_at_done", {31'd0, StallM}, 32'd0);
        else if (stale)
            check(StallF === 1'b1 && InstrValidF === 1'b0, "stale_discarded",
                  {30'd0, StallF, InstrValidF}, 32'd2);
        else
            check(StallF === 1'b0, "stallF_at_done", {31'd0, StallF}, 32'd0);
        if (is_data) begin
            DataReqM = 1'b0; d_pend = 1'b0;
        end else if (!stale) begin
            InstrReqF = 1'b0; i_pend = 1'b0;
        end
    endtask

    // Monitor: every completion pulse must match the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (DataDoneM === 1'b1) begin
                if (dq.size() == 0) check(1'b0, "unexpected_DataDoneM", 32'd1, 32'd0);
                else begin
                    e = dq.pop_front();
                    check(ReadDataM === e.v, "ReadDataM", ReadDataM, e.v);
                    check(MemErr === e.err, "MemErr_at_data_done", {31'd0, MemErr}, {31'd0, e.err});
                end
            end
            if (InstrValidF === 1'b1) begin
                if (iq.size() == 0) check(1'b0, "unexpected_InstrValidF", 32'd1, 32'd0);
                else begin
                    e = iq.pop_front();
                    check(InstrF === e.v, "InstrF", InstrF, e.v);
                    check(MemErr === e.err, "MemErr_at_instr_done", {31'd0, MemErr}, {31'd0, e.err});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  k, n, fk;
        bit  bad;
        rst_n = 1'b0;
        InstrReqF = 1'b0; PCF = 32'd0; FlushF = 1'b0;
        DataReqM = 1'b0; DataWeM = 1'b0; ALUResultM = 32'd0; WriteDataM = 32'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        d_pend = 1'b0; i_pend = 1'b0; d_we = 1'b0;
        d_addr = 32'd0; d_wdata = 32'd0; i_pc = 32'd0;
        last_data_m = 1'b0; rd_m = 32'd0; err_m = 1'b0;

        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Contention straight out of reset: data first, then alternate.
        req_data(1'b0, 32'h200, 32'd0);
        req_instr(32'h0);
        serve(2, 0, 32'hA5A5_0001, 32'd0);
        req_data(1'b0, 32'h300, 32'd0);
        serve(3, 0, 32'h0000_0013, 32'd0);
        serve(1, 0, 32'hCAFE_0002, 32'd0);

        // Plain load with a two-cycle memory.
        req_data(1'b0, 32'h100, 32'd0);
        serve(2, 0, 32'hDEAD_BEEF, 32'd0);

        // Fetch redirected one cycle before the ack, then the new target.
        req_instr(32'h40);
        serve(3, 2, 32'h1111_1111, 32'h80);
        serve(1, 0, 32'h2222_2222, 32'd0);

        // Store leaves the load data register alone.
        req_data(1'b1, 32'h400, 32'h1234_5678);
        serve(3, 0, 32'hFFFF_FFFF, 32'd0);
        check(ReadDataM === 32'hDEAD_BEEF, "store_keeps_ReadDataM", ReadDataM, 32'hDEAD_BEEF);

        // Memory never answers: abort after TO wait cycles, error is sticky.
        req_data(1'b0, 32'h500, 32'd0);
        serve(99, 0, 32'd0, 32'd0);
        check(MemErr === 1'b1, "MemErr_set", {31'd0, MemErr}, 32'd1);
        req_instr(32'h600);
        serve(2, 0, 32'h0000_0033, 32'd0);

        // Reset in the middle of a load, followed by a late ack.
        req_data(1'b0, 32'h700, 32'd0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (mem_req !== 1'b1 && k < 6);
        check(mem_req === 1'b1, "rst_test_grant", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check(mem_req === 1'b0, "async_reset_drops_req", {31'd0, mem_req}, 32'd0);
        check_zero_outputs("mid_reset");
        DataReqM = 1'b0; d_pend = 1'b0;
        last_data_m = 1'b0; rd_m = 32'd0; err_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_ack = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            bad |= (mem_req !== 1'b0 || DataDoneM !== 1'b0 || InstrValidF !== 1'b0);
            @(negedge clk);
        end
        check(!bad, "late_ack_ignored", {31'd0, bad}, 32'd0);
        check(ReadDataM === 32'd0, "late_ack_no_data", ReadDataM, 32'd0);

        // Randomised traffic: mixed loads, stores, fetches, flushes, timeouts.
        for (int t = 0; t < 300; t++) begin
            if (!d_pend && ($urandom % 2 == 0)) req_data(1'($urandom % 2), $urandom, $urandom);
            if (!i_pend && ($urandom % 2 == 0)) req_instr($urandom);
            if (!d_pend && !i_pend) begin
                if ($urandom % 2 == 0) req_data(1'($urandom % 2), $urandom, $urandom);
                else req_instr($urandom);
            end
            n  = $urandom_range(1, TO + 2);
            fk = ($urandom % 4 == 0) ? $urandom_range(1, n) : 0;
            serve(n, fk, $urandom, $urandom);
        end
        for (int t = 0; t < 4; t++) begin
            if (d_pend || i_pend) serve(1, 0, $urandom, 32'd0);
        end
        repeat (3) @(negedge clk);
        check(dq.size() == 0 && iq.size() == 0, "all_completions_seen",
              dq.size() + iq.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
